// File: rtl/bmult_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bmult_sched_pkg
// Brief    : Shared types, widths and the round-robin pick function used by
//            the Bmult30x30 scheduler and its arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bmult_sched_pkg;

    localparam int OP_W       = 30;
    localparam int PROD_W     = 60;
    // Upper bound on requesters; tags and pick vectors are sized for it so
    // the package stays independent of any one instance's NREQ.
    localparam int c_max_req  = 16;
    localparam int c_tag_id_w = 4;

    typedef struct packed {
        logic                  v;
        logic [c_tag_id_w-1:0] id;
    } tag_t;

    // One-hot grant for the first set bit of valid[0..n-1], searching
    // upward from ptr and wrapping at n.
    function automatic logic [c_max_req-1:0] rr_pick(
        input logic [c_max_req-1:0]  valid,
        input logic [c_tag_id_w-1:0] ptr,
        input int                    n
    );
        logic [c_max_req-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < c_max_req; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k < n) && !found && valid[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmult_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bmult_rr_arbiter
// Brief    : Combinational round-robin pick plus the rotating priority
//            pointer. Reusable in front of any single shared arithmetic unit.
// Revision : 1.0 - initial release
// ============================================================================
module bmult_rr_arbiter
    import bmult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_valid,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_grant_id,
    output logic            o_grant_any
);

    logic [ID_W-1:0]       r_ptr;
    logic [c_max_req-1:0]  w_valid_ext;
    logic [c_max_req-1:0]  w_pick;
    logic [c_tag_id_w-1:0] w_ptr_ext;
    logic                  w_any;

    // Pick the winner; grants are forced off while reset is held.
    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[NREQ-1:0]   = i_valid;
        w_ptr_ext               = '0;
        w_ptr_ext[ID_W-1:0]     = r_ptr;
        w_pick                  = rr_pick(w_valid_ext, w_ptr_ext, NREQ);
        w_any                   = (|w_pick) & ~rst;
        o_grant                 = rst ? '0 : w_pick[NREQ-1:0];
        o_grant_id              = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                o_grant_id = ID_W'(i);
            end
        end
    end

    assign o_grant_any = w_any;

    // Move priority to the requester after the winner; hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (o_grant_id == ID_W'(NREQ - 1)) ? '0 : o_grant_id + ID_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bmult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bmult_rr_scheduler
// Brief    : Shares one pipelined Bmult30x30 multiplier among NREQ
//            requesters. Round-robin issue, ID tags travel alongside the
//            multiplier pipeline, registered product returned to the issuer.
//            Optional per-requester grant counters: define BMULT_RR_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bmult_rr_scheduler
    import bmult_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 2,
    parameter int ID_W     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [OP_W-1:0]      mult_a,
    output logic [OP_W-1:0]      mult_b,
    input  logic [PROD_W-1:0]    mult_p,
    output logic [NREQ-1:0]      res_valid,
    output logic [ID_W-1:0]      res_id,
    output logic [PROD_W-1:0]    res_p,
`ifdef BMULT_RR_STATS_EN
    input  logic                 stats_clr,
    output logic [NREQ*16-1:0]   grant_cnt,
`endif
    output logic                 busy
);

    logic [NREQ-1:0]       w_grant;
    logic [ID_W-1:0]       w_grant_id;
    logic                  w_grant_any;
    logic [OP_W-1:0]       w_sel_a;
    logic [OP_W-1:0]       w_sel_b;

    logic [OP_W-1:0]       r_mult_a;
    logic [OP_W-1:0]       r_mult_b;
    logic                  r_issue_v;
    logic [c_tag_id_w-1:0] r_issue_id;

    tag_t                  r_tag [MULT_LAT];
    tag_t                  w_tail;
    logic                  w_tag_any;
    logic [NREQ-1:0]       w_res_onehot;

    logic [NREQ-1:0]       r_res_valid;
    logic [ID_W-1:0]       r_res_id;
    logic [PROD_W-1:0]     r_res_p;

    bmult_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (req_valid),
        .o_grant     (w_grant),
        .o_grant_id  (w_grant_id),
        .o_grant_any (w_grant_any)
    );

    // The grant only ever lands on a valid requester, so grant == handshake.
    assign req_ready = w_grant;

    // Route the winner's operand pair toward the issue registers.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a = req_a[OP_W*i +: OP_W];
                w_sel_b = req_b[OP_W*i +: OP_W];
            end
        end
    end

    // Issue stage: operands hold when idle so the multiplier inputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mult_a   <= '0;
            r_mult_b   <= '0;
            r_issue_v  <= 1'b0;
            r_issue_id <= '0;
        end else begin
            r_issue_v <= w_grant_any;
            if (w_grant_any) begin
                r_mult_a   <= w_sel_a;
                r_mult_b   <= w_sel_b;
                r_issue_id <= c_tag_id_w'(w_grant_id);
            end
        end
    end

    // Tag pipe: one stage per multiplier cycle so the tail lines up with mult_p.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < MULT_LAT; j++) begin
                r_tag[j] <= '0;
            end
        end else begin
            r_tag[0] <= {r_issue_v, r_issue_id};
            for (int j = 1; j < MULT_LAT; j++) begin
                r_tag[j] <= r_tag[j-1];
            end
        end
    end

    // Tail decode and in-flight summary.
    always_comb begin
        w_tail    = r_tag[MULT_LAT-1];
        w_tag_any = 1'b0;
        for (int j = 0; j < MULT_LAT; j++) begin
            w_tag_any = w_tag_any | r_tag[j].v;
        end
        w_res_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_res_onehot[i] = (w_tail.id == c_tag_id_w'(i));
        end
    end

    // Output stage: capture the product and strobe the owning requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= '0;
            r_res_id    <= '0;
            r_res_p     <= '0;
        end else if (w_tail.v) begin
            r_res_valid <= w_res_onehot;
            r_res_id    <= w_tail.id[ID_W-1:0];
            r_res_p     <= mult_p;
        end else begin
            r_res_valid <= '0;
        end
    end

    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_p     = r_res_p;
    assign busy      = r_issue_v | w_tag_any | (|r_res_valid);

`ifdef BMULT_RR_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
            logic [15:0] r_cnt;

            // Saturating handshake count; a clear with a grant restarts at 1.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (stats_clr) begin
                    r_cnt <= w_grant[gi] ? 16'd1 : 16'd0;
                end else if (w_grant[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign grant_cnt[16*gi +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_bmult_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bmult_rr_scheduler
// Brief    : Self-checking bench for bmult_rr_scheduler with a behavioural
//            pipelined multiplier and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bmult_rr_scheduler;

    localparam int NREQ     = 4;
    localparam int MULT_LAT = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [59:0] p;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*30-1:0] req_a;
    logic [NREQ*30-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [29:0]       mult_a;
    logic [29:0]       mult_b;
    logic [59:0]       mult_p;
    logic [NREQ-1:0]   res_valid;
    logic [1:0]        res_id;
    logic [59:0]       res_p;
    logic              busy;
`ifdef BMULT_RR_STATS_EN
    logic              stats_clr;
    logic [NREQ*16-1:0] grant_cnt;
`endif

    exp_t sb[$];
    exp_t e_push;
    exp_t e_mon;
    int   tests;
    int   fails;
    logic mon_en;
    logic [59:0] mp_pipe [MULT_LAT];

    bmult_rr_scheduler #(
        .NREQ     (NREQ),
        .MULT_LAT (MULT_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_p    (mult_p),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_p     (res_p),
`ifdef BMULT_RR_STATS_EN
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared multiplier with MULT_LAT register stages.
    always @(posedge clk) begin
        mp_pipe[0] <= 60'(mult_a) * 60'(mult_b);
        for (int j = 1; j < MULT_LAT; j++) mp_pipe[j] <= mp_pipe[j-1];
    end
    assign mult_p = mp_pipe[MULT_LAT-1];

    // Record expected result on every accepted handshake.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e_push.id = 2'(i);
                    e_push.p  = 60'(req_a[30*i +: 30]) * 60'(req_b[30*i +: 30]);
                    sb.push_back(e_push);
                end
            end
        end
    end

    // Compare each returned result against the oldest outstanding entry.
    always @(posedge clk) begin
        #1;
        if (mon_en && (res_valid !== 4'b0000)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: res_valid=%b res_id=%0d res_p=%h, required no result",
                         res_valid, res_id, res_p);
            end else begin
                e_mon = sb.pop_front();
                if (res_id !== e_mon.id || res_p !== e_mon.p ||
                    res_valid !== (4'b0001 << e_mon.id)) begin
                    fails++;
                    $display("FAIL result: got valid=%b id=%0d p=%h, required valid=%b id=%0d p=%h",
                             res_valid, res_id, res_p, 4'b0001 << e_mon.id, e_mon.id, e_mon.p);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[30*i +: 30] = 30'($urandom);
            req_b[30*i +: 30] = 30'($urandom);
        end
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: req_ready=%b, required 0000", req_ready);
        end
        tests++;
        if (res_valid !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: res_valid=%b busy=%b, required 0000/0", res_valid, busy);
        end
        tests++;
        if (mult_a !== 30'd0 || mult_b !== 30'd0) begin
            fails++;
            $display("FAIL reset_mult: mult_a=%h mult_b=%h, required 0/0", mult_a, mult_b);
        end
        tests++;
        if (res_p !== 60'd0 || res_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_res: res_p=%h res_id=%0d, required 0/0", res_p, res_id);
        end
        @(negedge clk);
        mon_en    = 1'b1;
        rst       = 1'b0;
        req_valid = '0;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL idle_ready: req_ready=%b, required 0000", req_ready);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid       = 4'b0010;
        req_a[30 +: 30] = 30'h3FFFFFFF;
        req_b[30 +: 30] = 30'h3FFFFFFF;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL single_grant: req_ready=%b, required 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL single_busy: busy=%b, required 1", busy);
        end
        repeat (MULT_LAT) @(negedge clk);
        tests++;
        if (res_valid !== 4'b0000) begin
            fails++;
            $display("FAIL single_early: res_valid=%b, required 0000", res_valid);
        end
        @(negedge clk);
        tests++;
        if (res_valid !== 4'b0010 || res_p !== 60'hFFFFFFF80000001) begin
            fails++;
            $display("FAIL single_latency: res_valid=%b res_p=%h, required 0010/0FFFFFFF80000001",
                     res_valid, res_p);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[30*i +: 30] = 30'(i + 1);
            req_b[30*i +: 30] = 30'd1000;
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = 4'b0001 << (k % 4);
            tests++;
            if (req_ready !== exp_g) begin
                fails++;
                $display("FAIL rr_grant[%0d]: req_ready=%b, required %b", k, req_ready, exp_g);
            end
            @(negedge clk);
        end
        req_valid = '0;
        drain();
    endtask

    task automatic test_sparse();
        logic [3:0] exp_seq [3];
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b0001;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[30*i +: 30] = 30'($urandom);
            req_b[30*i +: 30] = 30'($urandom);
        end
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (req_ready !== exp_seq[k]) begin
                fails++;
                $display("FAIL sparse_grant[%0d]: req_ready=%b, required %b", k, req_ready, exp_seq[k]);
            end
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL sparse_idle: req_ready=%b, required 0000", req_ready);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_a[30 +: 30] = 30'($urandom);
            req_b[30 +: 30] = 30'($urandom);
            req_valid       = 4'b0010;
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (res_valid !== 4'b0000) begin
                fails++;
                $display("FAIL midflight_res[%0d]: res_valid=%b, required 0000", k, res_valid);
            end
        end
        tests++;
        if (busy !== 1'b0 || mult_a !== 30'd0) begin
            fails++;
            $display("FAIL midflight_state: busy=%b mult_a=%h, required 0/0", busy, mult_a);
        end
        rst       = 1'b0;
        req_valid = '1;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL midflight_ptr: req_ready=%b, required 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        drain();
    endtask

    task automatic test_boundary();
        @(negedge clk);
        req_valid        = 4'b0001;
        req_a[0 +: 30]   = 30'd0;
        req_b[0 +: 30]   = 30'h2AAAAAAA;
        @(negedge clk);
        req_valid        = 4'b1000;
        req_a[90 +: 30]  = 30'd1;
        req_b[90 +: 30]  = 30'h3FFFFFFF;
        @(negedge clk);
        req_valid        = '0;
        drain();
        tests++;
        if (res_p !== 60'h3FFFFFFF || res_id !== 2'd3) begin
            fails++;
            $display("FAIL boundary_hold: res_p=%h res_id=%0d, required 3FFFFFFF/3", res_p, res_id);
        end
    endtask

`ifdef BMULT_RR_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        tests++;
        if (grant_cnt !== '0) begin
            fails++;
            $display("FAIL stats_reset: grant_cnt=%h, required 0", grant_cnt);
        end
        req_a[0 +: 30] = 30'd7;
        req_b[0 +: 30] = 30'd9;
        req_valid      = 4'b0001;
        repeat (70000) @(negedge clk);
        tests++;
        if (grant_cnt[15:0] !== 16'hFFFF || grant_cnt[31:16] !== 16'h0000) begin
            fails++;
            $display("FAIL stats_sat: cnt0=%h cnt1=%h, required FFFF/0000", grant_cnt[15:0], grant_cnt[31:16]);
        end
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        req_valid = '0;
        #1;
        tests++;
        if (grant_cnt[15:0] !== 16'd1) begin
            fails++;
            $display("FAIL stats_clr: cnt0=%h, required 0001", grant_cnt[15:0]);
        end
        drain();
    endtask
`endif

    initial begin
        tests     = 0;
        fails     = 0;
        mon_en    = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
`ifdef BMULT_RR_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_sparse();
        test_reset_midflight();
        test_boundary();
`ifdef BMULT_RR_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bmult_rr_scheduler.md
Name: bmult_rr_scheduler

Overview:
- Round-robin scheduler that shares one pipelined Bmult30x30 bit-heap multiplier among NREQ requesters.
- Accepts at most one operand pair per cycle and registers it onto the multiplier inputs.
- Tracks each operation's requester ID through the fixed multiplier latency, then returns the registered 60-bit product to the requester that issued it.
- Sits between client datapaths and the single shared multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- MULT_LAT, 2, cycles from mult_a/mult_b changing to the matching mult_p being valid (bit-heap gen plus compressor register stages).
- ID_W, $clog2(NREQ), requester-ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*30  flat operands A; slice i is [30*i+29:30*i].
- req_b  in  NREQ*30  flat operands B; same slicing as req_a.
- req_ready  out  NREQ  one-hot grant; handshake occurs when req_valid[i] & req_ready[i].
- mult_a  out  30  registered operand A to the multiplier.
- mult_b  out  30  registered operand B to the multiplier.
- mult_p  in  60  product from the multiplier.
- res_valid  out  NREQ  one-hot result strobe, one cycle wide.
- res_id  out  ID_W  requester ID of the current result.
- res_p  out  60  registered product.
- busy  out  1  high while any operation is in flight (issue stage, tag pipe, or output stage).

Behaviour:
- Arbitration:
  - Combinational round-robin over req_valid, starting the search at pointer rr_ptr.
  - req_ready is one-hot on the winner and all-zero when no request is valid.
  - Requesters have no backpressure. Results are never stalled.
- Pointer:
  - On a grant to i, rr_ptr <= (i+1) mod NREQ.
  - With no grant, rr_ptr holds.
  - Reset value is 0.
- Issue stage:
  - On a handshake at edge t, mult_a/mult_b <= the winner's operands, and issue_v <= 1, issue_id <= i.
  - With no handshake, mult_a/mult_b hold their previous values and issue_v <= 0.
- Tag pipe:
  - MULT_LAT-deep shift register of {v, id}, fed from {issue_v, issue_id}.
  - Its tail aligns with mult_p.
- Output stage:
  - When the tail v=1: res_p <= mult_p, res_id <= tail id, res_valid <= one-hot(tail id).
  - Otherwise res_valid <= 0, and res_p/res_id hold.
- Latency: a request accepted at edge t produces res_valid during cycle t+MULT_LAT+2. Throughput is 1 per cycle.
- Ordering: results leave in issue order. A requester may have multiple operations in flight.
- Simultaneous grant and result for the same requester in one cycle is legal and independent.
- Reset:
  - Clears rr_ptr, issue_v, all tag-pipe valids, res_valid, mult_a, mult_b, res_p and res_id.
  - Reset mid-operation discards every in-flight operation; no res_valid follows for them.
  - req_ready is 0 while rst=1.
- busy = issue_v | any tag-pipe v | |res_valid.
- Arithmetic: unsigned 30x30 -> 60. The scheduler never modifies data.

Optional Feature:
- Macro: BMULT_RR_STATS_EN.
- With the macro defined:
  - Adds output grant_cnt (NREQ*16): per-requester saturating 16-bit counts of accepted handshakes.
  - Counters hold at 16'hFFFF and clear on rst.
  - Adds input stats_clr (1), which synchronously zeroes all counters. A grant in the same cycle counts as 1 after the clear.
- Without it: neither port exists, and there is no counter logic.

Decomposition:
- Package bmult_sched_pkg:
  - OP_W=30 and PROD_W=60.
  - typedef tag_t struct {logic v; logic [ID_W-1:0] id}.
  - Function rr_pick(valid, ptr) returning a one-hot grant.
- Sub-module bmult_rr_arbiter: combinational pick plus the rr_ptr register. It is reusable for other shared arithmetic units.

Test Plan:
- Single request: req 1 with A=30'h3FFFFFFF, B=30'h3FFFFFFF at t=5 -> res_valid=4'b0010 at cycle 9 (MULT_LAT=2), res_p=60'hFFFFFFF80000001.
- All four valid continuously for 8 cycles, rr_ptr=0 -> grants 0,1,2,3,0,1,2,3. Results follow in the same order, back-to-back, with the correct products (A=i+1, B=1000).
- Sparse requests: only reqs 2 and 0 valid, rr_ptr=3 -> grant 0, then 2, then 0. No idle grants, and req_ready is 0 when nothing is valid.
- Reset mid-flight: issue 3 ops, assert rst one cycle later -> no res_valid afterwards, busy=0, rr_ptr=0, mult_a=0.
- Zero and boundary operands: A=0, B=30'h2AAAAAAA -> res_p=0. A=1, B=30'h3FFFFFFF -> res_p=60'h3FFFFFFF.
- STATS_EN: 70000 grants to req 0 -> grant_cnt[15:0]=16'hFFFF. stats_clr together with a grant -> 1 on the next cycle.
